fp_mul_pipe: RTL and testbench

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_round_pack.sv | 79 +++++++
 rtl/fp_mul_pipe.sv | 134 +++++++++++++
 tb/tb_fp_mul_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions and
// the canonical quiet-NaN encoding for any exponent/fraction width.
package fp_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_W         = 4;

    // Positive sign, all-ones exponent, only the fraction MSB set (quiet bit).
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

    // Subnormals land in ZERO: they are flushed on input.
    function automatic fp_class_e fp_class(input logic exp_zero,
                                           input logic exp_ones,
                                           input logic frac_zero);
        if (exp_zero)
            return ZERO;
        else if (!exp_ones)
            return NORM;
        else if (frac_zero)
            return INF;
        else
            return NAN;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final multiplier stage: normalise the raw significand product, round to
// nearest-even, detect over/underflow and pack the result word with flags.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                          i_sign,
    input  logic signed [EXP_W+1:0]       i_exp,
    input  fp_class_e                     i_cls,
    input  logic                          i_inv,
    input  logic [2*(MAN_W+1)-1:0]        i_prod,
    output logic [EXP_W+MAN_W:0]          o_word,
    output logic [FLAG_W-1:0]             o_flags
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int PROD_W = 2 * (MAN_W + 1);
    localparam int E_W    = EXP_W + 2;
    localparam logic signed [E_W-1:0] EMAX = E_W'((1 << EXP_W) - 1);

    logic                         w_top;
    logic [PROD_W-2:0]            w_norm;
    logic [MAN_W-1:0]             w_mant;
    logic                         w_guard;
    logic                         w_sticky;
    logic                         w_round_up;
    logic [MAN_W:0]               w_mant_r;
    logic signed [E_W-1:0]        w_exp_n;
    logic signed [E_W-1:0]        w_exp_r;
    logic                         w_inexact;

    // Product of two [1,2) significands lies in [1,4); the leading one sits
    // at bit PROD_W-1 or PROD_W-2 and is dropped after alignment.
    assign w_top      = i_prod[PROD_W-1];
    assign w_norm     = w_top ? i_prod[PROD_W-2:0] : {i_prod[PROD_W-3:0], 1'b0};
    assign w_mant     = w_norm[PROD_W-2 -: MAN_W];
    assign w_guard    = w_norm[PROD_W-2-MAN_W];
    assign w_sticky   = |w_norm[PROD_W-3-MAN_W:0];
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_r   = {1'b0, w_mant} + (MAN_W+1)'(w_round_up);
    assign w_exp_n    = i_exp + $signed({{(E_W-1){1'b0}}, w_top});
    assign w_exp_r    = w_exp_n + $signed({{(E_W-1){1'b0}}, w_mant_r[MAN_W]});
    assign w_inexact  = w_guard | w_sticky;

    always_comb begin
        o_word  = '0;
        o_flags = '0;
        case (i_cls)
            NAN: begin
                o_word                = W'(canon_nan(EXP_W, MAN_W));
                o_flags[FLAG_INVALID] = i_inv;
            end
            INF: begin
                o_word = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
            ZERO: begin
                o_word = {i_sign, {(W-1){1'b0}}};
            end
            default: begin
                if (w_exp_r >= EMAX) begin
                    o_word                 = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    o_flags[FLAG_OVERFLOW] = 1'b1;
                    o_flags[FLAG_INEXACT]  = 1'b1;
                end else if (w_exp_r <= 0) begin
                    o_word                  = {i_sign, {(W-1){1'b0}}};
                    o_flags[FLAG_UNDERFLOW] = 1'b1;
                    o_flags[FLAG_INEXACT]   = 1'b1;
                end else begin
                    // A rounding carry leaves the stored fraction at zero.
                    o_word                = {i_sign, w_exp_r[EXP_W-1:0], w_mant_r[MAN_W-1:0]};
                    o_flags[FLAG_INEXACT] = w_inexact;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-style multiplier with valid/ready handshaking; the whole
// pipe freezes when the output is held by the consumer.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     mul1,
    input  logic [EXP_W+MAN_W:0]     mul2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     product,
    output logic [FLAG_W-1:0]        flags
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int E_W    = EXP_W + 2;
    localparam logic signed [E_W-1:0] BIAS = E_W'((1 << (EXP_W - 1)) - 1);

    logic [EXP_W-1:0]       w_ea, w_eb;
    logic [MAN_W-1:0]       w_fa, w_fb;
    fp_class_e              w_ca, w_cb, w_cls;
    logic                   w_inv;
    logic signed [E_W-1:0]  w_esum;
    logic                   w_stall;
    logic [W-1:0]           w_rp_word;
    logic [FLAG_W-1:0]      w_rp_flags;

    logic                   r_s1_valid;
    logic                   r_s1_sign;
    logic signed [E_W-1:0]  r_s1_exp;
    fp_class_e              r_s1_cls;
    logic                   r_s1_inv;
    logic [SIG_W-1:0]       r_s1_siga, r_s1_sigb;

    logic                   r_s2_valid;
    logic                   r_s2_sign;
    logic signed [E_W-1:0]  r_s2_exp;
    fp_class_e              r_s2_cls;
    logic                   r_s2_inv;
    logic [PROD_W-1:0]      r_s2_prod;

    logic                   r_out_valid;
    logic [W-1:0]           r_product;
    logic [FLAG_W-1:0]      r_flags;

    assign w_ea = mul1[W-2 -: EXP_W];
    assign w_eb = mul2[W-2 -: EXP_W];
    assign w_fa = mul1[MAN_W-1:0];
    assign w_fb = mul2[MAN_W-1:0];
    assign w_ca = fp_class(w_ea == '0, &w_ea, w_fa == '0);
    assign w_cb = fp_class(w_eb == '0, &w_eb, w_fb == '0);
    assign w_esum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;

    // Special-case priority: NaN beats inf*0, which beats inf, which beats zero.
    always_comb begin
        w_cls = NORM;
        w_inv = 1'b0;
        if (w_ca == NAN || w_cb == NAN) begin
            w_cls = NAN;
        end else if ((w_ca == INF && w_cb == ZERO) || (w_ca == ZERO && w_cb == INF)) begin
            w_cls = NAN;
            w_inv = 1'b1;
        end else if (w_ca == INF || w_cb == INF) begin
            w_cls = INF;
        end else if (w_ca == ZERO || w_cb == ZERO) begin
            w_cls = ZERO;
        end
    end

    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !rst || !w_stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_flags     <= '0;
        end else if (!w_stall) begin
            r_s1_valid  <= in_valid;
            r_s2_valid  <= r_s1_valid;
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_product <= w_rp_word;
                r_flags   <= w_rp_flags;
            end
        end
    end

    // Datapath registers need no reset: their contents are qualified by the valids.
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_s1_sign <= mul1[W-1] ^ mul2[W-1];
            r_s1_exp  <= w_esum;
            r_s1_cls  <= w_cls;
            r_s1_inv  <= w_inv;
            r_s1_siga <= {1'b1, w_fa};
            r_s1_sigb <= {1'b1, w_fb};

            r_s2_sign <= r_s1_sign;
            r_s2_exp  <= r_s1_exp;
            r_s2_cls  <= r_s1_cls;
            r_s2_inv  <= r_s1_inv;
            r_s2_prod <= r_s1_siga * r_s1_sigb;
        end
    end

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .i_sign  (r_s2_sign),
        .i_exp   (r_s2_exp),
        .i_cls   (r_s2_cls),
        .i_inv   (r_s2_inv),
        .i_prod  (r_s2_prod),
        .o_word  (w_rp_word),
        .o_flags (w_rp_flags)
    );

    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign flags     = r_flags;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed-vector bench for fp_mul_pipe at single-precision defaults.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mul1;
    logic [31:0] mul2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic [3:0]  flags;

    int n_vec = 0;
    int n_err = 0;

    localparam int NV = 15;
    localparam logic [31:0] VA [NV] = '{
        32'h40800000, 32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h7F800000,
        32'h00800000, 32'h00000001, 32'hC0000000, 32'hFF800000, 32'h7FC00001,
        32'h80000000, 32'h3F800001, 32'h3F800003, 32'h00000000, 32'h3F800000};
    localparam logic [31:0] VB [NV] = '{
        32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h40000000, 32'h00000000,
        32'h3F000000, 32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F800000,
        32'h40A00000, 32'h3FC00000, 32'h3FC00000, 32'hFF800000, 32'h3F800000};
    localparam logic [31:0] VP [NV] = '{
        32'h41000000, 32'h40100000, 32'h3F800002, 32'h7F800000, 32'h7FC00000,
        32'h00000000, 32'h00000000, 32'hC0C00000, 32'hFF800000, 32'h7FC00000,
        32'h80000000, 32'h3FC00002, 32'h3FC00004, 32'h7FC00000, 32'h3F800000};
    localparam logic [3:0] VF [NV] = '{
        4'h0, 4'h0, 4'h1, 4'h5, 4'h8,
        4'h3, 4'h0, 4'h0, 4'h0, 4'h0,
        4'h0, 4'h1, 4'h1, 4'h8, 4'h0};

    localparam logic [31:0] BA [4] = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h3FC00000};
    localparam logic [31:0] BB [4] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h3FC00000};
    localparam logic [31:0] BP [4] = '{32'h3F800000, 32'h40C00000, 32'h41000000, 32'h40100000};

    logic [31:0] got_q[$];
    int          drv_idx, drv_guard, mon_stall_left, stall_cycles;
    bit          drv_acc, mon_first;

    fp_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul1      (mul1),
        .mul2      (mul2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s 0x%08h", tag, got);
        end
    endtask

    // Issue one operand pair with out_ready high and check latency, product, flags.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ep, input logic [3:0] ef);
        int lat;
        mul1     = a;
        mul2     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_prod"}, product, ep);
        check({tag, "_flags"}, 32'(flags), 32'(ef));
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        mul1      = 32'h40800000;
        mul2      = 32'h40000000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        rst      = 1'b1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("rel_no_ghost", 32'(out_valid), 32'd0);

        for (int i = 0; i < NV; i++)
            run_one($sformatf("v%0d", i), VA[i], VB[i], VP[i], VF[i]);

        // Back-to-back burst with a five-cycle consumer stall after the first result.
        got_q.delete();
        drv_idx        = 0;
        drv_guard      = 0;
        mon_stall_left = 0;
        mon_first      = 1'b1;
        stall_cycles   = 0;
        out_ready      = 1'b1;
        fork
            begin
                while (drv_idx < 4 && drv_guard < 40) begin
                    in_valid = 1'b1;
                    mul1     = BA[drv_idx];
                    mul2     = BB[drv_idx];
                    @(negedge clk);
                    drv_acc = in_ready;
                    @(posedge clk); #1;
                    drv_guard++;
                    if (drv_acc) drv_idx++;
                end
                in_valid = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 60 && got_q.size() < 4; cyc++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        got_q.push_back(product);
                        if (mon_first) begin
                            mon_first      = 1'b0;
                            mon_stall_left = 5;
                        end
                    end else if (out_valid && !out_ready) begin
                        stall_cycles++;
                        check("stall_in_ready", 32'(in_ready), 32'd0);
                    end
                    @(posedge clk); #1;
                    if (mon_stall_left > 0) begin
                        out_ready = 1'b0;
                        mon_stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            end
        join
        out_ready = 1'b1;
        check("burst_accepted", 32'(drv_idx), 32'd4);
        check("burst_count", 32'(got_q.size()), 32'd4);
        check("burst_stall_cycles", 32'(stall_cycles), 32'd5);
        for (int i = 0; i < 4; i++)
            check($sformatf("burst_r%0d", i), (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF, BP[i]);
        repeat (3) @(posedge clk);
        #1;
        check("burst_no_dup", 32'(out_valid), 32'd0);

        // Reset with two operations in flight.
        in_valid = 1'b1;
        mul1     = 32'h40400000;
        mul2     = 32'h40000000;
        @(posedge clk); #1;
        mul1 = 32'h40A00000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("midrst_flush%0d", k), 32'(out_valid), 32'd0);
            if (k == 0) check("midrst_rel_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        run_one("after_rst", 32'h40000000, 32'h40000000, 32'h40800000, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
